// File: rtl/parity_pkg.sv
// parity_pkg
// Shared types and constants for the serial parity detector.
//   state_t      : one-bit parity state, EVEN is the reset state
//   MAX_WORD_LEN : largest supported framing length
//   CNT_W        : width of the in-word bit counter
//   parity_flag  : maps a parity state onto the z polarity
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } state_t;

  localparam int MAX_WORD_LEN = 65535;
  localparam int CNT_W        = $clog2(MAX_WORD_LEN);

  // z is high in the "flagged" parity: odd when odd_flag=1, even otherwise.
  function automatic logic parity_flag(input state_t s, input logic odd_flag);
    parity_flag = odd_flag ? (s == ODD) : (s == EVEN);
  endfunction

endpackage

// File: rtl/parity_gen.sv
// parity_gen
// Moore serial parity detector. Samples x on every rising edge of clk and
// reports the running parity of the 1s seen, either free-running since reset
// (WORD_LEN=0) or restarting on every WORD_LEN-bit word.
//
// Parameters
//   ODD_FLAG  : 1 -> z=1 on odd count, 0 -> z=1 on even count
//   WORD_LEN  : 0 = free-running, 1..65535 = framing length in bits
// Ports
//   x         : in  serial data bit, sampled at posedge clk
//   clk       : in  rising-edge clock
//   z         : out parity flag, function of the state register only
//   rst       : in  synchronous active-high reset, priority over x
//   word_done : out one-cycle pulse on the edge that samples the last bit
//               of a word; constant 0 when WORD_LEN=0
//
// state | meaning
// EVEN  | even number of 1s in the current word / since reset
// ODD   | odd number of 1s in the current word / since reset
module parity_gen
  import parity_pkg::*;
#(
  parameter logic ODD_FLAG = 1'b1,
  parameter int   WORD_LEN = 0
) (
  input  logic x,
  input  logic clk,
  output logic z,
  input  logic rst,
  output logic word_done
);

  localparam logic FRAMED = (WORD_LEN > 0);
  localparam logic [CNT_W-1:0] LAST_BIT =
    FRAMED ? CNT_W'(WORD_LEN - 1) : '0;

  state_t           state;
  state_t           state_n;
  state_t           base;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             done_n;
  logic             x_s;

  // An unknown x is folded in as 0 so it cannot corrupt the parity state.
  assign x_s = (x === 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EVEN;
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      word_done <= done_n;
    end
  end

  always_comb begin
    base    = state;
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;

    // word_done high means the previous edge closed a word, so this bit is
    // the first of a new word and parity restarts from EVEN.
    if (FRAMED && word_done) begin
      base = EVEN;
    end

    if (x_s) begin
      state_n = (base == EVEN) ? ODD : EVEN;
    end else begin
      state_n = base;
    end

    if (FRAMED) begin
      if (cnt == LAST_BIT) begin
        cnt_n  = '0;
        done_n = 1'b1;
      end else begin
        cnt_n  = cnt + 1'b1;
      end
    end
  end

  assign z = parity_flag(state, ODD_FLAG);

endmodule

// File: tb/tb_parity_gen.sv
// tb_parity_gen
// Scoreboard bench for parity_gen. Three instances cover ODD_FLAG=1 and
// ODD_FLAG=0 in free-running mode and ODD_FLAG=1 with WORD_LEN=4. The driver
// pushes the hand-computed {z, word_done} expected after each edge; the
// monitor pops and compares on the following falling edge.
module tb_parity_gen;
  import parity_pkg::*;

  typedef struct {
    int   dut;
    logic ez;
    logic ewd;
    int   idx;
  } exp_t;

  logic clk = 1'b0;
  logic x0 = 1'b0, x1 = 1'b0, x2 = 1'b0;
  logic r0 = 1'b1, r1 = 1'b1, r2 = 1'b1;
  logic z0, z1, z2;
  logic wd0, wd1, wd2;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   seq    = 0;

  always #5 clk = ~clk;

  parity_gen #(.ODD_FLAG(1'b1), .WORD_LEN(0)) u_odd_free (
    .x(x0), .clk(clk), .z(z0), .rst(r0), .word_done(wd0)
  );

  parity_gen #(.ODD_FLAG(1'b0), .WORD_LEN(0)) u_even_free (
    .x(x1), .clk(clk), .z(z1), .rst(r1), .word_done(wd1)
  );

  parity_gen #(.ODD_FLAG(1'b1), .WORD_LEN(4)) u_odd_w4 (
    .x(x2), .clk(clk), .z(z2), .rst(r2), .word_done(wd2)
  );

  // Apply one bit to one DUT, then record what it must show after the edge.
  task automatic step(input int d, input logic xv, input logic rv,
                      input logic ez, input logic ewd);
    exp_t e;
    case (d)
      0:       begin x0 = xv; r0 = rv; end
      1:       begin x1 = xv; r1 = rv; end
      default: begin x2 = xv; r2 = rv; end
    endcase
    @(posedge clk);
    #1;
    e.dut = d;
    e.ez  = ez;
    e.ewd = ewd;
    e.idx = seq;
    seq++;
    sb.push_back(e);
  endtask

  // Vectors are written left to right in edge order; bit n-1 is the first edge.
  task automatic run_vec(input int d, input int n, input logic [15:0] xs,
                         input logic [15:0] zs, input logic [15:0] wds);
    for (int i = n - 1; i >= 0; i--) begin
      step(d, xs[i], 1'b0, zs[i], wds[i]);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic az, awd;
      e = sb.pop_front();
      case (e.dut)
        0:       begin az = z0; awd = wd0; end
        1:       begin az = z1; awd = wd1; end
        default: begin az = z2; awd = wd2; end
      endcase
      checks++;
      if (az !== e.ez) begin
        errors++;
        $display("FAIL z dut=%0d step=%0d actual=%b required=%b",
                 e.dut, e.idx, az, e.ez);
      end
      checks++;
      if (awd !== e.ewd) begin
        errors++;
        $display("FAIL word_done dut=%0d step=%0d actual=%b required=%b",
                 e.dut, e.idx, awd, e.ewd);
      end
    end
  end

  initial begin
    // Free-running, ODD_FLAG=1: reset, then a quiet line.
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec(0, 4, 16'b0000, 16'b0000, 16'b0000);

    // Free-running, ODD_FLAG=1: mixed stream.
    step(0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec(0, 12, 16'b0111_0110_0110, 16'b0101_1011_1011, 16'b0);

    // x held high, reset while ODD, rst wins over x, then toggling resumes.
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Free-running, ODD_FLAG=0: same stream, complemented flag.
    step(1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_vec(1, 12, 16'b0111_0110_0110, 16'b1010_0100_0100, 16'b0);

    // WORD_LEN=4: two words, the second starts from EVEN.
    step(2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_vec(2, 8, 16'b1110_1000, 16'b1011_1111, 16'b0001_0001);

    // WORD_LEN=4: reset after two bits drops the partial word.
    run_vec(2, 2, 16'b11, 16'b10, 16'b00);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec(2, 5, 16'b1111_0, 16'b1010_0, 16'b0001_0);

    // Let the monitor drain the last entry.
    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
